ps2_kbd_cmd_sched: RTL and testbench
====================================

Name: ps2_kbd_cmd_sched

Overview:
- Command scheduler that sits in front of the PS2 keyboard host's write/status interface.
- Arbitrates between two command sources:
  - the CPU register requester (1- or 2-byte commands);
  - an internal LED-sync requester that issues 0xED+LED-byte whenever the LED state changes or the keyboard reports BAT OK.
- Sequences the enqueue strobes, waits for ACK/ERR in the host status, and applies a timeout with bounded retries.

Parameters:
- TIMEOUT_US, 20000, microseconds to wait for ACK/ERR before declaring timeout (counted on ck1us).
- RETRIES, 2, extra attempts after a timeout (total attempts = RETRIES+1); ERR is never retried.
- GAP_US, 50, idle microseconds between a completed transaction and the next grant.

Ports:
- clk6x  in  1  48MHz system clock.
- resetn  in  1  reset, asynchronous, active-low.
- ck1us  in  1  1us-spaced pulse, 1 cycle wide.
- cpu_req_i  in  1  1-cycle pulse: CPU requests a command; ignored while cpu_busy_o=1.
- cpu_two_i  in  1  1=command+data (2 bytes), 0=single byte; sampled with cpu_req_i.
- cpu_cmd_i  in  8  command byte; sampled with cpu_req_i.
- cpu_data_i  in  8  data byte; sampled with cpu_req_i.
- cpu_busy_o  out  1  CPU request latched and not yet completed.
- cpu_done_o  out  1  1-cycle pulse when the CPU transaction completes.
- cpu_stat_o  out  8  last CPU result: 0x00 none, 0x01 pending, 0xFA ACK, 0xFE ERR, 0xFF timeout.
- led_i  in  3  desired keyboard LEDs {caps,num,scroll}.
- kbd_bat_ok_i  in  1  pulse: BAT OK (0xAA) received from the keyboard.
- kbd_stat_i  in  8  host status: 0x00/0x01/0xFA/0xFE.
- kbd_wcmddata_o  out  8  byte presented to the host TX FIFO.
- kbd_enq_cmd1_o  out  1  enqueue a 1-byte command, or the data byte of a 2-byte command.
- kbd_enq_cmd2_o  out  1  enqueue the command byte of a 2-byte command.

Behaviour:
- Reset (async, resetn=0) values:
  - FSM=IDLE, all strobes 0, kbd_wcmddata_o=0x00;
  - cpu_busy_o=0, cpu_done_o=0, cpu_stat_o=0x00;
  - led_pend=1, led_sent=3'b000, last_grant=LED, counters 0.
- Reset mid-transaction abandons the transaction silently (no done pulse).
- CPU latch: cpu_req_i while !cpu_busy_o stores cmd/data/two and sets cpu_busy_o=1 and cpu_stat_o=0x01 on the next edge.
- LED pending: led_pend is set when led_i != led_sent, or on a kbd_bat_ok_i pulse. The pulse is never lost, even mid-transaction.
- Arbitration (IDLE only, gap expired):
  - one pending source is granted directly;
  - if both are pending, the source not granted last wins;
  - an LED grant snapshots led_i into led_cur and clears led_pend.
- FSM states:
  - IDLE: grant as above. A 2-byte grant -> ISSUE2A; a 1-byte grant -> ISSUE1.
  - ISSUE1: one cycle with kbd_enq_cmd1_o=1 and the cmd byte -> SETTLE.
  - ISSUE2A: one cycle with kbd_enq_cmd2_o=1 and the cmd byte -> ISSUE2B.
  - ISSUE2B: one cycle with kbd_enq_cmd1_o=1 and the data byte -> SETTLE. The LED data byte is {5'b0, led_cur}.
  - SETTLE: one cycle, lets the host status become 0x01 -> WAIT. Clears the timeout counter.
  - WAIT:
    - 0xFA -> result ACK; 0xFE -> result ERR; either goes to DONE.
    - Otherwise the counter increments on each ck1us.
    - When the counter reaches TIMEOUT_US: if attempts < RETRIES, increment attempts and re-enter the issue state; else result 0xFF -> DONE.
  - DONE: one cycle.
    - CPU owner: cpu_stat_o=result, cpu_done_o=1, cpu_busy_o=0.
    - LED owner: ACK sets led_sent=led_cur. ERR or timeout sets led_sent=led_cur as well (no livelock), and raises no CPU flag.
    - Clears attempts, loads the gap counter, goes to GAP.
  - GAP: counts GAP_US ck1us pulses -> IDLE.
- Strobe rules: at most one of the enq strobes is high in any cycle. kbd_wcmddata_o holds its value when no strobe is active.
- Simultaneous events:
  - A cpu_req_i arriving during an LED transaction is latched and served after the gap.
  - A led_i change during an LED transaction re-pends, because led_i != led_sent after DONE.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.

Test Plan:
- cpu_req with cmd=0xF4, two=0; host status returns 0xFA 100us later -> one enq_cmd1 cycle carrying 0xF4; cpu_stat=0x01 then 0xFA; one cpu_done pulse.
- cpu_req with cmd=0xF3, data=0x20, two=1 -> enq_cmd2 with 0xF3, then enq_cmd1 with 0x20 on the next cycle; status 0xFA -> cpu_stat=0xFA.
- led_i 000->101 -> enq_cmd2 0xED then enq_cmd1 0x05; ACK -> led_sent=101; no cpu_done; no further LED traffic.
- Status held at 0x01, TIMEOUT_US=20, RETRIES=2 -> 3 identical issue sequences spaced 20us apart; then cpu_stat=0xFF and cpu_done pulses.
- CPU and LED pending simultaneously, last_grant=LED -> CPU served first; LED served after GAP_US; a second tie grants LED.
- Status 0xFE on a CPU command -> no retry; cpu_stat=0xFE. kbd_bat_ok pulse with led_i==led_sent -> LED command is still reissued.

Source files
------------

// File: rtl/ps2_kbd_cmd_sched.sv
// ps2_kbd_cmd_sched
// Command scheduler in front of the PS2 keyboard host write/status interface.
// Arbitrates between a CPU register requester (1- or 2-byte commands) and an
// internal LED-sync requester (0xED + LED byte), sequences the host enqueue
// strobes, waits for ACK/ERR in the host status and retries on timeout.
//
// Ports:
//   clk6x, resetn        48 MHz clock, asynchronous active-low reset
//   ck1us                1-cycle pulse every microsecond
//   cpu_req_i/two/cmd/data  CPU command request (sampled with cpu_req_i)
//   cpu_busy_o/done_o/stat_o  CPU request status and result
//   led_i, kbd_bat_ok_i  desired LEDs and keyboard BAT OK pulse
//   kbd_stat_i           host status (0x00/0x01/0xFA/0xFE)
//   kbd_wcmddata_o, kbd_enq_cmd1_o, kbd_enq_cmd2_o  host TX FIFO write side
module ps2_kbd_cmd_sched #(
    parameter int TIMEOUT_US = 20000,
    parameter int RETRIES    = 2,
    parameter int GAP_US     = 50
) (
    input  logic       clk6x,
    input  logic       resetn,
    input  logic       ck1us,
    input  logic       cpu_req_i,
    input  logic       cpu_two_i,
    input  logic [7:0] cpu_cmd_i,
    input  logic [7:0] cpu_data_i,
    output logic       cpu_busy_o,
    output logic       cpu_done_o,
    output logic [7:0] cpu_stat_o,
    input  logic [2:0] led_i,
    input  logic       kbd_bat_ok_i,
    input  logic [7:0] kbd_stat_i,
    output logic [7:0] kbd_wcmddata_o,
    output logic       kbd_enq_cmd1_o,
    output logic       kbd_enq_cmd2_o
);

    localparam int TW = ($clog2(TIMEOUT_US + 1) > 0) ? $clog2(TIMEOUT_US + 1) : 1;
    localparam int AW = ($clog2(RETRIES + 1) > 0) ? $clog2(RETRIES + 1) : 1;
    localparam int GW = ($clog2(GAP_US + 1) > 0) ? $clog2(GAP_US + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_US);
    localparam logic [AW-1:0] RMAX = AW'(RETRIES);
    localparam logic [GW-1:0] GMAX = GW'(GAP_US);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE1, S_ISSUE2A, S_ISSUE2B, S_SETTLE, S_WAIT, S_DONE, S_GAP
    } state_t;

    state_t        state_reg, state_next;
    logic          owner_led_reg, owner_led_next;   // 1: current transaction is LED sync
    logic          last_led_reg, last_led_next;     // 1: last grant went to LED
    logic          cpu_two_reg, cpu_two_next;
    logic [7:0]    cpu_cmd_reg, cpu_cmd_next;
    logic [7:0]    cpu_data_reg, cpu_data_next;
    logic          cpu_busy_reg, cpu_busy_next;
    logic          cpu_done_reg, cpu_done_next;
    logic [7:0]    cpu_stat_reg, cpu_stat_next;
    logic          led_pend_reg, led_pend_next;
    logic [2:0]    led_sent_reg, led_sent_next;
    logic [2:0]    led_cur_reg, led_cur_next;
    logic [7:0]    result_reg, result_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic [AW-1:0] att_cnt_reg, att_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic          enq1_reg, enq1_next;
    logic          enq2_reg, enq2_next;

    logic          led_req;
    logic          grant_led;
    logic          grant_two;
    logic          led_pend_clr;
    logic          own_two;
    logic [7:0]    own_cmd;
    logic [7:0]    own_data;

    // The sticky register only remembers BAT OK pulses (and the post-reset
    // sync); an LED mismatch is evaluated live, so a change made during an
    // LED transaction shows up as pending once led_sent is updated in DONE.
    assign led_req  = led_pend_reg | (led_i != led_sent_reg);
    assign own_two  = owner_led_reg | cpu_two_reg;
    assign own_cmd  = owner_led_reg ? 8'hED : cpu_cmd_reg;
    assign own_data = owner_led_reg ? {5'b00000, led_cur_reg} : cpu_data_reg;

    always_comb begin
        state_next     = state_reg;
        owner_led_next = owner_led_reg;
        last_led_next  = last_led_reg;
        cpu_two_next   = cpu_two_reg;
        cpu_cmd_next   = cpu_cmd_reg;
        cpu_data_next  = cpu_data_reg;
        cpu_busy_next  = cpu_busy_reg;
        cpu_done_next  = 1'b0;
        cpu_stat_next  = cpu_stat_reg;
        led_sent_next  = led_sent_reg;
        led_cur_next   = led_cur_reg;
        result_next    = result_reg;
        to_cnt_next    = to_cnt_reg;
        att_cnt_next   = att_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        wdata_next     = wdata_reg;
        enq1_next      = 1'b0;
        enq2_next      = 1'b0;
        led_pend_clr   = 1'b0;
        grant_led      = 1'b0;
        grant_two      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cpu_busy_reg || led_req) begin
                    // On a tie the source not granted last wins.
                    grant_led      = led_req && (!cpu_busy_reg || !last_led_reg);
                    grant_two      = grant_led || cpu_two_reg;
                    owner_led_next = grant_led;
                    last_led_next  = grant_led;
                    if (grant_led) begin
                        led_cur_next = led_i;
                        led_pend_clr = 1'b1;
                    end
                    wdata_next = grant_led ? 8'hED : cpu_cmd_reg;
                    enq2_next  = grant_two;
                    enq1_next  = !grant_two;
                    state_next = grant_two ? S_ISSUE2A : S_ISSUE1;
                end
            end
            S_ISSUE1: state_next = S_SETTLE;
            S_ISSUE2A: begin
                wdata_next = own_data;
                enq1_next  = 1'b1;
                state_next = S_ISSUE2B;
            end
            S_ISSUE2B: state_next = S_SETTLE;
            S_SETTLE: begin
                to_cnt_next = '0;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                if (kbd_stat_i == 8'hFA || kbd_stat_i == 8'hFE) begin
                    result_next = kbd_stat_i;
                    state_next  = S_DONE;
                end else if (to_cnt_reg == TMAX) begin
                    if (att_cnt_reg < RMAX) begin
                        att_cnt_next = att_cnt_reg + 1'b1;
                        wdata_next   = own_cmd;
                        enq2_next    = own_two;
                        enq1_next    = !own_two;
                        state_next   = own_two ? S_ISSUE2A : S_ISSUE1;
                    end else begin
                        result_next = 8'hFF;
                        state_next  = S_DONE;
                    end
                end else if (ck1us) begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                if (owner_led_reg) begin
                    // Failed LED syncs are also marked sent to avoid livelock.
                    led_sent_next = led_cur_reg;
                end else begin
                    cpu_stat_next = result_reg;
                    cpu_done_next = 1'b1;
                    cpu_busy_next = 1'b0;
                end
                att_cnt_next = '0;
                gap_cnt_next = GMAX;
                state_next   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = S_IDLE;
                end else if (ck1us) begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // CPU latch; busy is still set during DONE, so this cannot collide
        // with the completion above.
        if (cpu_req_i && !cpu_busy_reg) begin
            cpu_busy_next = 1'b1;
            cpu_stat_next = 8'h01;
            cpu_two_next  = cpu_two_i;
            cpu_cmd_next  = cpu_cmd_i;
            cpu_data_next = cpu_data_i;
        end

        // A BAT OK pulse in the same cycle as an LED grant must survive.
        if (kbd_bat_ok_i)
            led_pend_next = 1'b1;
        else if (led_pend_clr)
            led_pend_next = 1'b0;
        else
            led_pend_next = led_pend_reg;
    end

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            owner_led_reg <= 1'b1;
            last_led_reg  <= 1'b1;
            cpu_two_reg   <= 1'b0;
            cpu_cmd_reg   <= 8'h00;
            cpu_data_reg  <= 8'h00;
            cpu_busy_reg  <= 1'b0;
            cpu_done_reg  <= 1'b0;
            cpu_stat_reg  <= 8'h00;
            led_pend_reg  <= 1'b1;
            led_sent_reg  <= 3'b000;
            led_cur_reg   <= 3'b000;
            result_reg    <= 8'h00;
            to_cnt_reg    <= '0;
            att_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            wdata_reg     <= 8'h00;
            enq1_reg      <= 1'b0;
            enq2_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_led_reg <= owner_led_next;
            last_led_reg  <= last_led_next;
            cpu_two_reg   <= cpu_two_next;
            cpu_cmd_reg   <= cpu_cmd_next;
            cpu_data_reg  <= cpu_data_next;
            cpu_busy_reg  <= cpu_busy_next;
            cpu_done_reg  <= cpu_done_next;
            cpu_stat_reg  <= cpu_stat_next;
            led_pend_reg  <= led_pend_next;
            led_sent_reg  <= led_sent_next;
            led_cur_reg   <= led_cur_next;
            result_reg    <= result_next;
            to_cnt_reg    <= to_cnt_next;
            att_cnt_reg   <= att_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            wdata_reg     <= wdata_next;
            enq1_reg      <= enq1_next;
            enq2_reg      <= enq2_next;
        end
    end

    assign cpu_busy_o     = cpu_busy_reg;
    assign cpu_done_o     = cpu_done_reg;
    assign cpu_stat_o     = cpu_stat_reg;
    assign kbd_wcmddata_o = wdata_reg;
    assign kbd_enq_cmd1_o = enq1_reg;
    assign kbd_enq_cmd2_o = enq2_reg;

endmodule

// File: tb/tb_ps2_kbd_cmd_sched.sv
// Testbench for ps2_kbd_cmd_sched: a host responder answers each issued
// command, a monitor logs enqueue strobes and CPU completions, and the
// checks compare them to expectations from a table, hand sequences and a
// transaction-level model driven by random stimulus.
`timescale 1ns/1ps
module tb_ps2_kbd_cmd_sched;

    localparam int TO = 20;
    localparam int RT = 2;
    localparam int GP = 5;
    localparam int USCLK = 4;

    logic       clk6x = 1'b0;
    logic       resetn = 1'b0;
    logic       ck1us = 1'b0;
    logic       cpu_req_i = 1'b0;
    logic       cpu_two_i = 1'b0;
    logic [7:0] cpu_cmd_i = 8'h00;
    logic [7:0] cpu_data_i = 8'h00;
    logic       cpu_busy_o;
    logic       cpu_done_o;
    logic [7:0] cpu_stat_o;
    logic [2:0] led_i = 3'b000;
    logic       kbd_bat_ok_i = 1'b0;
    logic [7:0] kbd_stat_i = 8'h00;
    logic [7:0] kbd_wcmddata_o;
    logic       kbd_enq_cmd1_o;
    logic       kbd_enq_cmd2_o;

    ps2_kbd_cmd_sched #(.TIMEOUT_US(TO), .RETRIES(RT), .GAP_US(GP)) dut (
        .clk6x(clk6x), .resetn(resetn), .ck1us(ck1us),
        .cpu_req_i(cpu_req_i), .cpu_two_i(cpu_two_i),
        .cpu_cmd_i(cpu_cmd_i), .cpu_data_i(cpu_data_i),
        .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o), .cpu_stat_o(cpu_stat_o),
        .led_i(led_i), .kbd_bat_ok_i(kbd_bat_ok_i), .kbd_stat_i(kbd_stat_i),
        .kbd_wcmddata_o(kbd_wcmddata_o),
        .kbd_enq_cmd1_o(kbd_enq_cmd1_o), .kbd_enq_cmd2_o(kbd_enq_cmd2_o)
    );

    always #5 clk6x = ~clk6x;

    typedef struct {
        bit         is2;
        logic [7:0] b;
        int         t;
    } ent_t;

    typedef struct {
        bit         two;
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] resp;
        logic [7:0] exp_stat;
        int         att;
    } vec_t;

    ent_t       log_q[$];
    logic [7:0] done_q[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] resp_code = 8'hFA;
    int         resp_dly = 3;
    logic [2:0] led_sent_m = 3'b000;

    initial forever begin
        repeat (USCLK - 1) @(negedge clk6x);
        ck1us = 1'b1;
        @(negedge clk6x);
        ck1us = 1'b0;
    end

    initial forever begin
        @(posedge clk6x);
        cyc++;
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every enqueue strobe and CPU completion
    initial forever begin
        @(negedge clk6x);
        if (kbd_enq_cmd1_o || kbd_enq_cmd2_o) begin
            check("strobe_excl", {31'd0, kbd_enq_cmd1_o & kbd_enq_cmd2_o}, 32'd0);
            log_q.push_back('{kbd_enq_cmd2_o, kbd_wcmddata_o, cyc});
        end
        if (cpu_done_o) done_q.push_back(cpu_stat_o);
    end

    // Host responder: pending after the last byte, answer resp_dly us later
    initial forever begin
        @(negedge clk6x);
        if (kbd_enq_cmd1_o) begin
            kbd_stat_i = 8'h01;
            repeat (resp_dly * USCLK) @(negedge clk6x);
            if (resp_code != 8'h01) kbd_stat_i = resp_code;
        end
    end

    // Reference rules: ACK/ERR end after one attempt, silence retries.
    function automatic logic [7:0] model_stat(logic [7:0] resp);
        return (resp == 8'hFA) ? 8'hFA : (resp == 8'hFE) ? 8'hFE : 8'hFF;
    endfunction

    function automatic int model_att(logic [7:0] resp);
        return (resp == 8'hFA || resp == 8'hFE) ? 1 : RT + 1;
    endfunction

    task automatic pop_entry(output ent_t e, output bit ok);
        int n = 0;
        while (log_q.size() == 0 && n < 3000) begin
            @(negedge clk6x);
            n++;
        end
        ok = (log_q.size() > 0);
        if (ok) e = log_q.pop_front();
        else e = '{1'b0, 8'h00, 0};
    endtask

    task automatic expect_txn(string nm, bit two, logic [7:0] cmd, logic [7:0] data, int att);
        ent_t e, e2;
        bit   ok;
        int   prev_t = 0;
        for (int a = 0; a < att; a++) begin
            pop_entry(e, ok);
            check({nm, "_cmd"}, {22'd0, ok, e.is2, e.b}, {22'd0, 1'b1, two, cmd});
            if (two) begin
                pop_entry(e2, ok);
                check({nm, "_data"}, {22'd0, ok, e2.is2, e2.b}, {22'd0, 1'b1, 1'b0, data});
                check({nm, "_adj"}, e2.t - e.t, 32'd1);
                e = e2;
            end
            if (a > 0)
                check({nm, "_retry_gap"},
                      {31'd0, (e.t - prev_t >= TO * USCLK - 2) && (e.t - prev_t <= TO * USCLK + 10)},
                      32'd1);
            prev_t = e.t;
        end
    endtask

    task automatic wait_done(string nm, logic [7:0] exp);
        int n = 0;
        while (done_q.size() == 0 && n < 4000) begin
            @(negedge clk6x);
            n++;
        end
        check({nm, "_done"}, done_q.size(), 32'd1);
        if (done_q.size() > 0) check({nm, "_stat"}, {24'd0, done_q.pop_front()}, {24'd0, exp});
    endtask

    task automatic quiet(string nm);
        repeat ((TO + GP + 6) * USCLK) @(negedge clk6x);
        check({nm, "_no_traffic"}, log_q.size(), 32'd0);
        check({nm, "_no_done"}, done_q.size(), 32'd0);
        log_q.delete();
        done_q.delete();
    endtask

    task automatic cpu_send(bit two, logic [7:0] cmd, logic [7:0] data);
        @(negedge clk6x);
        cpu_req_i = 1'b1;
        cpu_two_i = two;
        cpu_cmd_i = cmd;
        cpu_data_i = data;
        @(negedge clk6x);
        cpu_req_i = 1'b0;
    endtask

    task automatic run_cpu(string nm, bit two, logic [7:0] cmd, logic [7:0] data,
                           logic [7:0] resp, logic [7:0] exp_stat, int att);
        resp_code = resp;
        cpu_send(two, cmd, data);
        check({nm, "_pend"}, {23'd0, cpu_busy_o, cpu_stat_o}, {23'd0, 1'b1, 8'h01});
        expect_txn(nm, two, cmd, data, att);
        wait_done(nm, exp_stat);
        quiet(nm);
    endtask

    task automatic run_led(string nm, logic [2:0] newled, logic [7:0] resp);
        resp_code = resp;
        @(negedge clk6x);
        led_i = newled;
        if (newled != led_sent_m) begin
            expect_txn(nm, 1'b1, 8'hED, {5'd0, newled}, model_att(resp));
            led_sent_m = newled;
        end
        quiet(nm);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b0, 8'hF4, 8'h00, 8'hFA, 8'hFA, 1};
        vt[1] = '{1'b1, 8'hF3, 8'h20, 8'hFA, 8'hFA, 1};
        vt[2] = '{1'b0, 8'hFF, 8'h00, 8'hFE, 8'hFE, 1};
        vt[3] = '{1'b1, 8'hF0, 8'h02, 8'h01, 8'hFF, 3};
        vt[4] = '{1'b0, 8'hEE, 8'h00, 8'h01, 8'hFF, 3};
        vt[5] = '{1'b1, 8'hED, 8'h07, 8'hFE, 8'hFE, 1};

        // Reset state
        repeat (5) @(negedge clk6x);
        check("rst_strobes", {30'd0, kbd_enq_cmd1_o, kbd_enq_cmd2_o}, 32'd0);
        check("rst_wdata", {24'd0, kbd_wcmddata_o}, 32'd0);
        check("rst_cpu", {22'd0, cpu_busy_o, cpu_done_o, cpu_stat_o}, 32'd0);

        // Post-reset LED sync with led_i = 000
        resetn = 1'b1;
        expect_txn("rst_led", 1'b1, 8'hED, 8'h00, 1);
        quiet("rst_led");

        // Table-driven CPU transactions
        for (int i = 0; i < 6; i++)
            run_cpu($sformatf("vec%0d", i), vt[i].two, vt[i].cmd, vt[i].data,
                    vt[i].resp, vt[i].exp_stat, vt[i].att);

        // LED change, then BAT OK with no change still reissues
        run_led("led101", 3'b101, 8'hFA);
        @(negedge clk6x);
        kbd_bat_ok_i = 1'b1;
        @(negedge clk6x);
        kbd_bat_ok_i = 1'b0;
        expect_txn("bat_ok", 1'b1, 8'hED, 8'h05, 1);
        quiet("bat_ok");

        // Arbitration ties: after an LED grant CPU wins, after a CPU grant LED wins
        resp_code = 8'hFA;
        led_i = 3'b001;
        expect_txn("tie_led1", 1'b1, 8'hED, 8'h01, 1);
        cpu_send(1'b0, 8'hF4, 8'h00);
        led_i = 3'b010;
        expect_txn("tie_cpuA", 1'b0, 8'hF4, 8'h00, 1);
        led_i = 3'b011;
        wait_done("tie_cpuA", 8'hFA);
        cpu_send(1'b1, 8'hF3, 8'h20);
        expect_txn("tie_led3", 1'b1, 8'hED, 8'h03, 1);
        expect_txn("tie_cpuB", 1'b1, 8'hF3, 8'h20, 1);
        wait_done("tie_cpuB", 8'hFA);
        quiet("tie");
        led_sent_m = 3'b011;

        // Random transactions against the reference rules
        for (int i = 0; i < 12; i++) begin
            int         k = $urandom_range(0, 3);
            int         r = $urandom_range(0, 5);
            logic [7:0] resp = (r < 3) ? 8'hFA : (r < 5) ? 8'hFE : 8'h01;
            logic [7:0] c = 8'($urandom);
            logic [7:0] d = 8'($urandom);
            if (k < 3)
                run_cpu($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), c, d,
                        resp, model_stat(resp), model_att(resp));
            else
                run_led($sformatf("rndled%0d", i), 3'($urandom_range(0, 7)), resp);
        end

        // Reset mid-transaction: abandoned silently, LED resync afterwards
        resp_code = 8'h01;
        cpu_send(1'b0, 8'hF5, 8'h00);
        expect_txn("midrst", 1'b0, 8'hF5, 8'h00, 1);
        repeat (4) @(negedge clk6x);
        resetn = 1'b0;
        repeat (20) @(negedge clk6x);
        check("midrst_cpu", {23'd0, cpu_busy_o, cpu_stat_o}, 32'd0);
        check("midrst_strobes", {30'd0, kbd_enq_cmd1_o, kbd_enq_cmd2_o}, 32'd0);
        resp_code = 8'hFA;
        resetn = 1'b1;
        expect_txn("midrst_led", 1'b1, 8'hED, {5'd0, led_i}, 1);
        quiet("midrst_led");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
